// File: rtl/usart_result_tx.sv
// usart_result_tx: buffers a result message and sends it as 8N1 UART frames, with rewind-to-replay.
module usart_result_tx #(
  parameter int CLKS_PER_BIT = 140,
  parameter int DEPTH = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       wr_last,
  output logic       wr_ready,
  input  logic       rewind_usart,
  output logic       tx,
  output logic       tx_led,
  output logic       msg_valid
);
  localparam int BW = $clog2(CLKS_PER_BIT + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state;
  logic [7:0] r_mem [DEPTH];
  logic [ADDR_W:0] r_wr_ptr, r_len;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [BW-1:0] r_baud;
  logic [2:0] r_bit;
  logic r_msg_valid, r_pending, r_tx, r_led;
  logic w_accept, w_start, w_bit_end, w_tx_next;
  logic [ADDR_W:0] w_idx;
  logic [7:0] w_byte;
  assign wr_ready = (r_state == IDLE) && !rewind_usart &&
                    !(r_wr_ptr == (ADDR_W+1)'(DEPTH) && !r_msg_valid);
  assign w_accept = wr_en & wr_ready;
  assign w_start = (r_state == IDLE) & rewind_usart & r_msg_valid;
  assign w_idx = r_msg_valid ? '0 : r_wr_ptr;
  assign w_bit_end = r_baud == BW'(CLKS_PER_BIT - 1);
  assign w_byte = r_mem[r_rd_ptr];
  // tx is a registered image of the state, so the line lags the FSM by one cycle
  assign w_tx_next = (r_state == DATA) ? w_byte[r_bit] : (r_state != START);
  assign tx = r_tx;
  assign tx_led = r_led;
  assign msg_valid = r_msg_valid;
  always_ff @(posedge clk)
    if (w_accept) r_mem[w_idx[ADDR_W-1:0]] <= wr_data;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_len <= '0;
      r_baud <= '0;
      r_bit <= '0;
      r_msg_valid <= 1'b0;
      r_pending <= 1'b0;
      r_tx <= 1'b1;
      r_led <= 1'b0;
    end else begin
      r_tx <= w_tx_next;
      r_led <= r_state != IDLE;
      if (r_state == IDLE) begin
        r_baud <= '0;
        if (w_start) begin
          r_rd_ptr <= '0;
          r_state <= START;
        end else if (w_accept) begin
          r_wr_ptr <= w_idx + (ADDR_W+1)'(1);
          r_msg_valid <= wr_last;
          if (wr_last) begin
            r_len <= w_idx + (ADDR_W+1)'(1);
            r_rd_ptr <= '0;
            r_state <= START;
          end
        end
      end else begin
        r_baud <= w_bit_end ? '0 : r_baud + BW'(1);
        r_pending <= r_pending | rewind_usart;
        if (w_bit_end)
          case (r_state)
            START: begin
              r_state <= DATA;
              r_bit <= '0;
            end
            DATA: begin
              r_bit <= r_bit + 3'd1;
              if (r_bit == 3'd7) r_state <= STOP;
            end
            default:
              // a rewind arriving in the very last stop cycle still counts
              if (r_pending | rewind_usart) begin
                r_rd_ptr <= '0;
                r_pending <= 1'b0;
                r_state <= START;
              end else if (({1'b0, r_rd_ptr} + (ADDR_W+1)'(1)) < r_len) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
                r_state <= START;
              end else r_state <= IDLE;
          endcase
      end
    end
endmodule

// File: tb/tb_usart_result_tx.sv
// tb_usart_result_tx: decodes the tx line offline and compares frames with the expected byte stream.
module tb_usart_result_tx;
  localparam int CPB = 4;
  localparam int FR = 10 * CPB;
  localparam int DEPTH = 32;
  logic clk = 0, reset = 1, wr_en = 0, wr_last = 0, rewind_usart = 0;
  logic [7:0] wr_data = 0;
  logic wr_ready, tx, tx_led, msg_valid;
  int total = 0, bad = 0;
  logic cap_tx [2000];
  logic cap_led [2000];
  logic [7:0] got_q[$], exp_q[$], msg[$];
  int led_n, first0, ferr;
  usart_result_tx #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready), .rewind_usart(rewind_usart), .tx(tx), .tx_led(tx_led),
    .msg_valid(msg_valid)
  );
  always #5 clk = ~clk;
  task automatic write_byte(input logic [7:0] d, input logic last);
    int t = 0;
    @(negedge clk);
    while (!wr_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    total++;
    if (t >= 1000) begin
      bad++;
      $display("FAIL write_wait wr_ready=%b required=1", wr_ready);
    end
    wr_en = 1;
    wr_data = d;
    wr_last = last;
    @(posedge clk);
    #1 wr_en = 0;
    wr_last = 0;
  endtask
  task automatic send_msg();
    foreach (msg[i]) write_byte(msg[i], i == msg.size() - 1);
  endtask
  task automatic pulse_rewind();
    @(negedge clk);
    rewind_usart = 1;
    @(posedge clk);
    #1 rewind_usart = 0;
  endtask
  task automatic capture(input int n, input int pulse_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i] = tx;
      cap_led[i] = tx_led;
      rewind_usart = (i == pulse_at);
    end
    rewind_usart = 0;
  endtask
  task automatic decode(input int n);
    int i = 0;
    logic [7:0] b;
    got_q.delete();
    led_n = 0;
    first0 = -1;
    ferr = 0;
    for (int j = 0; j < n; j++) led_n += int'(cap_led[j]);
    while (i < n) begin
      if (cap_tx[i] === 1'b0) begin
        if (first0 < 0) first0 = i;
        if (i + FR > n) begin
          ferr++;
          break;
        end
        for (int k = 0; k < 8; k++) b[k] = cap_tx[i + CPB * (k + 1) + CPB / 2];
        if (cap_tx[i + CPB / 2] !== 1'b0 || cap_tx[i + 9 * CPB + CPB / 2] !== 1'b1) ferr++;
        got_q.push_back(b);
        i += FR;
      end else i++;
    end
  endtask
  function automatic int frame_diff();
    int d = (got_q.size() != exp_q.size()) ? 1 : 0;
    if (d == 0) foreach (exp_q[i]) d += (got_q[i] !== exp_q[i]) ? 1 : 0;
    return d;
  endfunction
  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total += 3;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    if (tx_led !== 1'b0) begin bad++; $display("FAIL reset_led got=%b exp=0", tx_led); end
    if (msg_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", msg_valid); end
    reset = 0;
    @(negedge clk);
    total++;
    if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", wr_ready); end
  endtask
  task automatic test_basic();
    msg = '{8'h31, 8'h32, 8'h0A};
    send_msg();
    capture(160, -1);
    decode(160);
    exp_q = msg;
    total += 5;
    if (first0 !== 1) begin bad++; $display("FAIL basic_latency got=%0d exp=1", first0); end
    if (frame_diff() != 0) begin bad++; $display("FAIL basic_frames got=%0d frames exp=%0d", got_q.size(), exp_q.size()); end
    if (ferr != 0) begin bad++; $display("FAIL basic_framing errors=%0d exp=0", ferr); end
    if (led_n != 120) begin bad++; $display("FAIL basic_led got=%0d exp=120", led_n); end
    if (msg_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", msg_valid); end
  endtask
  task automatic test_rewind_idle();
    @(negedge clk);
    rewind_usart = 1;
    wr_en = 1;
    wr_data = 8'hFF;
    #1 total++;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL rewind_blocks_write got=%b exp=0", wr_ready); end
    @(posedge clk);
    #1 rewind_usart = 0;
    wr_en = 0;
    capture(160, -1);
    decode(160);
    exp_q = msg;
    total += 4;
    if (first0 !== 1) begin bad++; $display("FAIL rewind_idle_latency got=%0d exp=1", first0); end
    if (frame_diff() != 0) begin bad++; $display("FAIL rewind_idle_frames got=%0d frames exp=%0d", got_q.size(), exp_q.size()); end
    if (led_n != 120) begin bad++; $display("FAIL rewind_idle_led got=%0d exp=120", led_n); end
    if (ferr != 0) begin bad++; $display("FAIL rewind_idle_framing errors=%0d exp=0", ferr); end
  endtask
  task automatic test_rewind_mid(input int p);
    int f = p / FR;
    pulse_rewind();
    capture(400, p);
    decode(400);
    exp_q.delete();
    for (int i = 0; i <= f; i++) exp_q.push_back(msg[i]);
    foreach (msg[i]) exp_q.push_back(msg[i]);
    total += 3;
    if (frame_diff() != 0) begin bad++; $display("FAIL rewind_mid_frames p=%0d got=%0d frames exp=%0d", p, got_q.size(), exp_q.size()); end
    if (led_n != FR * exp_q.size()) begin bad++; $display("FAIL rewind_mid_led p=%0d got=%0d exp=%0d", p, led_n, FR * exp_q.size()); end
    if (ferr != 0) begin bad++; $display("FAIL rewind_mid_framing p=%0d errors=%0d exp=0", p, ferr); end
  endtask
  task automatic test_random();
    repeat (3) begin
      msg.delete();
      repeat ($urandom_range(1, 6)) msg.push_back(8'($urandom_range(0, 255)));
      send_msg();
      capture(msg.size() * FR + 40, -1);
      decode(msg.size() * FR + 40);
      exp_q = msg;
      total += 3;
      if (first0 !== 1) begin bad++; $display("FAIL random_latency got=%0d exp=1", first0); end
      if (frame_diff() != 0) begin bad++; $display("FAIL random_frames got=%0d frames exp=%0d", got_q.size(), exp_q.size()); end
      if (led_n != FR * msg.size()) begin bad++; $display("FAIL random_led got=%0d exp=%0d", led_n, FR * msg.size()); end
    end
  endtask
  task automatic test_full();
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < DEPTH; i++) write_byte(8'($urandom_range(0, 255)), 1'b0);
    @(negedge clk);
    total += 2;
    if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", wr_ready); end
    if (msg_valid !== 1'b0) begin bad++; $display("FAIL full_valid got=%b exp=0", msg_valid); end
    capture(60, -1);
    decode(60);
    total += 2;
    if (first0 != -1) begin bad++; $display("FAIL full_no_tx start_at=%0d exp=-1", first0); end
    if (led_n != 0) begin bad++; $display("FAIL full_led got=%0d exp=0", led_n); end
    reset = 1;
    @(negedge clk);
    reset = 0;
    msg.delete();
    repeat (DEPTH) msg.push_back(8'($urandom_range(0, 255)));
    send_msg();
    capture(DEPTH * FR + 40, -1);
    decode(DEPTH * FR + 40);
    exp_q = msg;
    total += 2;
    if (frame_diff() != 0) begin bad++; $display("FAIL full32_frames got=%0d frames exp=%0d", got_q.size(), exp_q.size()); end
    if (led_n != DEPTH * FR) begin bad++; $display("FAIL full32_led got=%0d exp=%0d", led_n, DEPTH * FR); end
  endtask
  task automatic test_rewind_no_msg();
    reset = 1;
    @(negedge clk);
    reset = 0;
    capture(100, 0);
    decode(100);
    total += 2;
    if (first0 != -1) begin bad++; $display("FAIL nomsg_tx start_at=%0d exp=-1", first0); end
    if (led_n != 0) begin bad++; $display("FAIL nomsg_led got=%0d exp=0", led_n); end
  endtask
  task automatic test_reset_mid();
    int i;
    msg = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    send_msg();
    capture(50, -1);
    #2 reset = 1;
    #1 total += 3;
    if (tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx got=%b exp=1", tx); end
    if (tx_led !== 1'b0) begin bad++; $display("FAIL async_reset_led got=%b exp=0", tx_led); end
    if (msg_valid !== 1'b0) begin bad++; $display("FAIL async_reset_valid got=%b exp=0", msg_valid); end
    @(negedge clk);
    reset = 0;
    capture(60, 0);
    decode(60);
    total += 2;
    if (first0 != -1) begin bad++; $display("FAIL post_reset_rewind start_at=%0d exp=-1", first0); end
    if (led_n != 0) begin bad++; $display("FAIL post_reset_led got=%0d exp=0", led_n); end
    send_msg();
    wr_en = 1;
    wr_data = 8'h55;
    for (i = 0; i < 500; i++) begin
      @(negedge clk);
      if (wr_ready) break;
    end
    total++;
    if (i != 2 * FR) begin bad++; $display("FAIL held_write_wait got=%0d exp=%0d", i, 2 * FR); end
    @(posedge clk);
    #1 wr_en = 0;
    total++;
    if (msg_valid !== 1'b0) begin bad++; $display("FAIL held_write_new_msg valid=%b exp=0", msg_valid); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_rewind_idle();
    test_rewind_mid(FR + CPB + int'($urandom_range(0, 8 * CPB - 1)));
    test_rewind_mid(3 * FR - 1);
    test_random();
    test_full();
    test_rewind_no_msg();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
